// File: rtl/memory_compute_pkg.sv
// Shared definitions for the memory_compute request scheduler:
// FSM state encoding, parameter defaults and a small index helper.
package memory_compute_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RETURN  = 2'd3
    } mcs_state_e;

    localparam int unsigned DEF_NUM_REQ       = 32'd4;
    localparam int unsigned DEF_NUM_FN_CALLS  = 32'd4;
    localparam int unsigned DEF_FN_CALL_WIDTH = 32'd8;
    localparam int unsigned DEF_DATA_WIDTH    = 32'd8;
    localparam int unsigned DEF_TIMEOUT       = 32'd16;

    // Increment modulo n, used for the round-robin pointer.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        if (v + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/memory_compute_scheduler_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at ptr and grants the first
// asserted one, returning both a one-hot grant and its index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 32'd4,
    localparam int unsigned IDW = (NUM_REQ > 32'd1) ? $clog2(NUM_REQ) : 32'd1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id,
    output logic               grant_valid
);

    // Priority scan beginning at the pointer position.
    always_comb begin
        int unsigned idx;
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = 32'd0;
        for (int unsigned k = 32'd0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
                grant_valid = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/memory_compute_scheduler.sv
// Batches calls from several requesters into one memory_compute transaction
// and routes the per-lane results back to the requester that owns each lane.
module memory_compute_scheduler
    import memory_compute_pkg::*;
#(
    parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
    parameter int unsigned NUM_FN_CALLS  = DEF_NUM_FN_CALLS,
    parameter int unsigned FN_CALL_WIDTH = DEF_FN_CALL_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*FN_CALL_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                    resp_valid,
    input  logic [NUM_REQ-1:0]                    resp_ready,
    output logic [DATA_WIDTH-1:0]                 resp_data,
    output logic [NUM_FN_CALLS-1:0]               mc_data_in_valid,
    input  logic                                  mc_data_in_ready,
    output logic [NUM_FN_CALLS*FN_CALL_WIDTH-1:0] mc_data_in,
    input  logic                                  mc_data_out_valid,
    output logic                                  mc_data_out_ready,
    input  logic [NUM_FN_CALLS*DATA_WIDTH-1:0]    mc_data_out,
    output logic                                  busy
);

    localparam int unsigned IDW = (NUM_REQ > 32'd1) ? $clog2(NUM_REQ) : 32'd1;
    localparam int unsigned LCW = $clog2(NUM_FN_CALLS + 32'd1);
    localparam int unsigned RTW = (NUM_FN_CALLS > 32'd1) ? $clog2(NUM_FN_CALLS) : 32'd1;
    localparam int unsigned CW  = $clog2(TIMEOUT) + 32'd1;

    mcs_state_e state_q, state_d;
    logic [LCW-1:0] lanes_q, lanes_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [RTW-1:0] ret_q, ret_d;
    logic [NUM_FN_CALLS-1:0][FN_CALL_WIDTH-1:0] lane_q, lane_d;
    logic [NUM_FN_CALLS-1:0][IDW-1:0]           owner_q, owner_d;
    logic [NUM_FN_CALLS-1:0][DATA_WIDTH-1:0]    res_q, res_d;

    logic [NUM_REQ-1:0] arb_req_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [IDW-1:0]     grant_id_s;
    logic               grant_valid_s;
    logic [IDW-1:0]     ret_owner_s;

    // Only offer requests to the arbiter while a lane is still free.
    always_comb begin
        if (state_q == ST_COLLECT && lanes_q < LCW'(NUM_FN_CALLS)) begin
            arb_req_s = req_valid;
        end else begin
            arb_req_s = '0;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (arb_req_s),
        .ptr         (ptr_q),
        .grant       (grant_s),
        .grant_id    (grant_id_s),
        .grant_valid (grant_valid_s)
    );

    assign ret_owner_s = owner_q[ret_q];
    assign busy        = !(state_q == ST_COLLECT && lanes_q == LCW'(0));

    // Next-state, batch bookkeeping and interface outputs.
    always_comb begin
        state_d           = state_q;
        lanes_d           = lanes_q;
        cnt_d             = cnt_q;
        ptr_d             = ptr_q;
        ret_d             = ret_q;
        lane_d            = lane_q;
        owner_d           = owner_q;
        res_d             = res_q;
        req_ready         = '0;
        resp_valid        = '0;
        resp_data         = '0;
        mc_data_in_valid  = '0;
        mc_data_in        = '0;
        mc_data_out_ready = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                // req_ready is combinational on req_valid, so keep it quiet in reset.
                if (!rst && grant_valid_s) begin
                    req_ready                        = grant_s;
                    lane_d[lanes_q[RTW-1:0]]         = req_data[grant_id_s*FN_CALL_WIDTH +: FN_CALL_WIDTH];
                    owner_d[lanes_q[RTW-1:0]]        = grant_id_s;
                    lanes_d                          = lanes_q + LCW'(1);
                    ptr_d                            = IDW'(wrap_inc(32'(grant_id_s), NUM_REQ));
                end else begin
                    req_ready = '0;
                end
                if (lanes_d != LCW'(0)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (lanes_d == LCW'(NUM_FN_CALLS) ||
                    (lanes_d != LCW'(0) && cnt_q == CW'(TIMEOUT - 32'd1))) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_ISSUE: begin
                for (int unsigned i = 32'd0; i < NUM_FN_CALLS; i++) begin
                    if (LCW'(i) < lanes_q) begin
                        mc_data_in_valid[i]                              = 1'b1;
                        mc_data_in[i*FN_CALL_WIDTH +: FN_CALL_WIDTH]     = lane_q[i];
                    end else begin
                        mc_data_in_valid[i] = 1'b0;
                    end
                end
                if (mc_data_in_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                mc_data_out_ready = 1'b1;
                if (mc_data_out_valid) begin
                    res_d   = mc_data_out;
                    ret_d   = RTW'(0);
                    state_d = ST_RETURN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RETURN: begin
                resp_valid[ret_owner_s] = 1'b1;
                resp_data               = res_q[ret_q];
                if (resp_ready[ret_owner_s]) begin
                    if (LCW'(ret_q) == lanes_q - LCW'(1)) begin
                        state_d = ST_COLLECT;
                        lanes_d = LCW'(0);
                        cnt_d   = CW'(0);
                        ret_d   = RTW'(0);
                    end else begin
                        ret_d = ret_q + RTW'(1);
                    end
                end else begin
                    ret_d = ret_q;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // State and batch storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            lanes_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ret_q   <= '0;
            lane_q  <= '0;
            owner_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            lanes_q <= lanes_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ret_q   <= ret_d;
            lane_q  <= lane_d;
            owner_q <= owner_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_memory_compute_scheduler.sv
// Self-checking bench for memory_compute_scheduler: table of single calls,
// directed batch/stall/reset sequences, and a randomized run against a model.
module tb_memory_compute_scheduler;

    localparam int NR = 4;
    localparam int NF = 4;
    localparam int FW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*FW-1:0]  req_data = '0;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready = '0;
    logic [DW-1:0]     resp_data;
    logic [NF-1:0]     mc_data_in_valid;
    logic              mc_data_in_ready = 1'b0;
    logic [NF*FW-1:0]  mc_data_in;
    logic              mc_data_out_valid = 1'b0;
    logic              mc_data_out_ready;
    logic [NF*DW-1:0]  mc_data_out = '0;
    logic              busy;

    always #5 clk = ~clk;

    memory_compute_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_data          (req_data),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_data         (resp_data),
        .mc_data_in_valid  (mc_data_in_valid),
        .mc_data_in_ready  (mc_data_in_ready),
        .mc_data_in        (mc_data_in),
        .mc_data_out_valid (mc_data_out_valid),
        .mc_data_out_ready (mc_data_out_ready),
        .mc_data_out       (mc_data_out),
        .busy              (busy)
    );

    typedef struct {
        int         owner;
        logic [7:0] res;
    } rsp_t;

    typedef struct {
        int         r;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Requester model
    logic [NR-1:0] pend = '0;
    logic [NR-1:0] hold = '0;
    logic [FW-1:0] rq_d [NR];
    int            ptr_m = 0;
    int            last_grant = -1;
    int            grant_cyc = 0;

    // Expected response stream and calls accepted but not yet issued
    rsp_t       exp_q [$];
    rsp_t       log_q [$];
    logic [7:0] acc_q [$];

    // memory_compute model
    int               stall_in_n = 0;
    bit               mc_rand = 1'b0;
    int               mc_lat_cfg = 2;
    bit               mc_pend = 1'b0;
    int               mc_lat_left = 0;
    logic [NF*DW-1:0] mc_res = '0;
    bit               prev_issue = 1'b0;
    logic [NF-1:0]    prev_mask = '0;
    logic [NF*FW-1:0] prev_mcdata = '0;
    logic [NF-1:0]    last_mask = '0;
    logic [NF*FW-1:0] last_mcdata = '0;
    int               issue_cyc = 0;
    int               issue_hs_cyc = 0;

    // Response side model
    bit          resp_rand = 1'b0;
    int          resp_hold_n = 0;
    bit          prev_resp_wait = 1'b0;
    logic [NR-1:0] prev_rv = '0;
    logic [DW-1:0] prev_rd = '0;
    int          resp_first_cyc = 0;
    int          resp_hs_cyc = 0;

    vec_t vecs [6];

    function automatic logic [7:0] mc_fn(input logic [7:0] x);
        return {4'b0000, x[7:4]} * {4'b0000, x[3:0]};
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_issue();
        int k;
        logic [NF-1:0] m;
        logic [FW-1:0] e;
        k = acc_q.size();
        m = '0;
        for (int i = 0; i < NF; i++) if (i < k) m[i] = 1'b1;
        check("batch_size", (k <= NF && k > 0), 1'b1);
        check("issue_mask", mc_data_in_valid, m);
        for (int i = 0; i < NF; i++) begin
            e = (i < k) ? acc_q[i] : 8'h00;
            check("issue_lane", mc_data_in[i*FW +: FW], e);
            mc_res[i*DW +: DW] = mc_fn(mc_data_in[i*FW +: FW]);
        end
        mc_pend     = 1'b1;
        mc_lat_left = mc_rand ? $urandom_range(0, 4) : mc_lat_cfg;
        last_mask   = mc_data_in_valid;
        last_mcdata = mc_data_in;
        acc_q.delete();
    endtask

    // One clock: sample DUT state at negedge, drive inputs, check the grant.
    task automatic step();
        logic [NR-1:0] rr;
        int w;
        rsp_t t;
        @(negedge clk);
        cyc++;
        mc_data_out_valid = 1'b0;
        mc_data_out       = '0;
        if (mc_pend) begin
            if (mc_lat_left > 0) begin
                mc_lat_left--;
            end else begin
                mc_data_out_valid = 1'b1;
                mc_data_out       = mc_res;
                if (mc_data_out_ready) mc_pend = 1'b0;
            end
        end
        mc_data_in_ready = 1'b0;
        if (mc_data_in_valid != '0) begin
            check("out_ready_in_issue", mc_data_out_ready, 1'b0);
            if (prev_issue) begin
                check("issue_mask_stable", mc_data_in_valid, prev_mask);
                check("issue_data_stable", mc_data_in, prev_mcdata);
            end else begin
                issue_cyc = cyc;
                if (mc_rand) stall_in_n = $urandom_range(0, 3);
            end
            prev_mask   = mc_data_in_valid;
            prev_mcdata = mc_data_in;
            if (stall_in_n > 0) begin
                stall_in_n--;
            end else begin
                mc_data_in_ready = 1'b1;
                issue_hs_cyc     = cyc;
                check_issue();
            end
            prev_issue = !mc_data_in_ready;
        end else begin
            prev_issue = 1'b0;
        end
        if (resp_hold_n > 0 && resp_valid != '0) begin
            rr = '0;
            resp_hold_n--;
        end else if (resp_rand) begin
            rr = NR'($urandom());
        end else begin
            rr = '1;
        end
        if (resp_valid != '0) begin
            check("resp_onehot", $onehot(resp_valid), 1'b1);
            if (prev_resp_wait) begin
                check("resp_valid_held", resp_valid, prev_rv);
                check("resp_data_held", resp_data, prev_rd);
            end else begin
                resp_first_cyc = cyc;
            end
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got valid %0h data %0h expected none", resp_valid, resp_data);
            end else begin
                check("resp_owner", resp_valid, NR'(1) << exp_q[0].owner);
                check("resp_data", resp_data, exp_q[0].res);
                if ((resp_valid & rr) != '0) begin
                    t = exp_q.pop_front();
                    log_q.push_back(t);
                    resp_hs_cyc = cyc;
                end
            end
            prev_resp_wait = ((resp_valid & rr) == '0);
            prev_rv        = resp_valid;
            prev_rd        = resp_data;
        end else begin
            prev_resp_wait = 1'b0;
        end
        resp_ready = rr;
        req_valid  = pend;
        for (int r = 0; r < NR; r++) req_data[r*FW +: FW] = rq_d[r];
        #1;
        check("req_ready_onehot0", $onehot0(req_ready), 1'b1);
        if (mc_data_in_valid != '0 || mc_data_out_ready || resp_valid != '0) begin
            check("req_ready_idle", req_ready, '0);
        end
        if (req_ready != '0) begin
            w = 0;
            for (int r = 0; r < NR; r++) if (req_ready[r]) w = r;
            check("grant_rr", w, rr_pick(req_valid, ptr_m));
            check("grant_has_valid", req_valid[w], 1'b1);
            acc_q.push_back(rq_d[w]);
            t.owner = w;
            t.res   = mc_fn(rq_d[w]);
            exp_q.push_back(t);
            ptr_m      = (w + 1) % NR;
            last_grant = w;
            grant_cyc  = cyc;
            if (!hold[w]) pend[w] = 1'b0;
            check("lanes_le_max", (acc_q.size() <= NF), 1'b1);
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((pend != '0 || exp_q.size() != 0 || acc_q.size() != 0 || mc_pend || busy) && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_busy", busy, 1'b0);
        check("drain_resp_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst              = 1'b1;
        req_valid        = '1;
        resp_ready       = '1;
        mc_data_in_ready = 1'b1;
        mc_data_out_valid = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, '0);
        check("rst_resp_valid", resp_valid, '0);
        check("rst_resp_data", resp_data, '0);
        check("rst_mc_in_valid", mc_data_in_valid, '0);
        check("rst_mc_in", mc_data_in, '0);
        check("rst_mc_out_ready", mc_data_out_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst              = 1'b0;
        req_valid        = '0;
        resp_ready       = '0;
        mc_data_in_ready = 1'b0;
        pend = '0;
        hold = '0;
        exp_q.delete();
        acc_q.delete();
        mc_pend        = 1'b0;
        prev_issue     = 1'b0;
        prev_resp_wait = 1'b0;
        stall_in_n     = 0;
        resp_hold_n    = 0;
        ptr_m          = 0;
    endtask

    task automatic send_four();
        rq_d[0] = 8'h12;
        rq_d[1] = 8'h23;
        rq_d[2] = 8'h34;
        rq_d[3] = 8'h45;
        pend    = '1;
    endtask

    initial begin
        logic [7:0] exp36 [4];
        exp36[0] = 8'h02;
        exp36[1] = 8'h06;
        exp36[2] = 8'h0C;
        exp36[3] = 8'h14;
        vecs[0] = '{2, 8'h56, 8'h1E};
        vecs[1] = '{0, 8'h12, 8'h02};
        vecs[2] = '{3, 8'h45, 8'h14};
        vecs[3] = '{1, 8'h23, 8'h06};
        vecs[4] = '{1, 8'h78, 8'h38};
        vecs[5] = '{3, 8'hFF, 8'hE1};
        for (int r = 0; r < NR; r++) rq_d[r] = '0;

        do_reset();

        // Single calls: each issues on timeout with a one-lane mask.
        for (int v = 0; v < 6; v++) begin
            rq_d[vecs[v].r] = vecs[v].d;
            pend[vecs[v].r] = 1'b1;
            log_q.delete();
            wait_idle(200);
            check("single_resp_count", log_q.size(), 1);
            if (log_q.size() > 0) begin
                check("single_owner", log_q[0].owner, vecs[v].r);
                check("single_result", log_q[0].res, vecs[v].exp);
            end
            check("timeout_latency", issue_cyc - grant_cyc, TO);
            check("single_mask", last_mask, 4'b0001);
        end

        // Four requesters at once: full batch, lanes in requester order.
        log_q.delete();
        send_four();
        wait_idle(200);
        check("full_mask", last_mask, 4'b1111);
        check("full_lanes", last_mcdata, 32'h45342312);
        check("full_issue_latency", issue_cyc - grant_cyc, 1);
        check("full_resp_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                check("full_owner", log_q[i].owner, i);
                check("full_result", log_q[i].res, exp36[i]);
            end
        end

        // One requester holding valid fills the whole batch.
        log_q.delete();
        rq_d[1] = 8'h78;
        pend[1] = 1'b1;
        hold[1] = 1'b1;
        for (int n = 0; n < 20 && acc_q.size() < 4; n++) step();
        pend[1] = 1'b0;
        hold[1] = 1'b0;
        wait_idle(200);
        check("hold_mask", last_mask, 4'b1111);
        check("hold_lanes", last_mcdata, 32'h78787878);
        check("hold_resp_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                check("hold_owner", log_q[i].owner, 1);
                check("hold_result", log_q[i].res, 8'h38);
            end
        end

        // Back-pressure on both the issue and the response handshakes.
        log_q.delete();
        stall_in_n  = 5;
        resp_hold_n = 3;
        rq_d[0] = 8'h34;
        pend[0] = 1'b1;
        wait_idle(200);
        check("issue_stall_cycles", issue_hs_cyc - issue_cyc, 5);
        check("resp_stall_cycles", resp_hs_cyc - resp_first_cyc, 3);
        check("stall_result", (log_q.size() == 1) ? log_q[0].res : 8'hXX, 8'h0C);

        // Randomized traffic against the model.
        mc_rand   = 1'b1;
        resp_rand = 1'b1;
        for (int n = 0; n < 800; n++) begin
            for (int r = 0; r < NR; r++) begin
                if (!pend[r] && $urandom_range(0, 5) == 0) begin
                    rq_d[r] = FW'($urandom());
                    pend[r] = 1'b1;
                end
            end
            step();
        end
        wait_idle(400);
        mc_rand   = 1'b0;
        resp_rand = 1'b0;

        // Reset while waiting on memory_compute abandons the batch.
        mc_lat_cfg = 8;
        log_q.delete();
        rq_d[2] = 8'h56;
        pend[2] = 1'b1;
        for (int n = 0; n < 60 && !mc_data_out_ready; n++) step();
        check("reached_wait", mc_data_out_ready, 1'b1);
        do_reset();
        mc_lat_cfg = 2;
        for (int n = 0; n < 12; n++) step();
        check("no_resp_after_reset", log_q.size(), 0);
        last_grant = -1;
        send_four();
        step();
        check("post_reset_first_grant", last_grant, 0);
        wait_idle(200);
        check("post_reset_resp_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                check("post_reset_owner", log_q[i].owner, i);
                check("post_reset_result", log_q[i].res, exp36[i]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_compute_scheduler.md
MEMORY_COMPUTE_SCHEDULER -- requirements
Module: memory_compute_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of independent requesters sharing one memory_compute instance.
REQ-002 Parameter NUM_FN_CALLS, default 4, lanes per memory_compute batch.
REQ-003 Parameter FN_CALL_WIDTH, default 8, width of one function-call operand word.
REQ-004 Parameter DATA_WIDTH, default 8, width of one lane result.
REQ-005 Parameter TIMEOUT, default 16, max cycles a partial batch waits before issue (>=1).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 req_valid  in  NUM_REQ  per-requester call valid.
REQ-009 req_ready  out  NUM_REQ  per-requester accept, at most one bit set.
REQ-010 req_data  in  NUM_REQ*FN_CALL_WIDTH  requester r call in bits [(r+1)*FN_CALL_WIDTH-1 : r*FN_CALL_WIDTH].
REQ-011 resp_valid  out  NUM_REQ  one-hot result valid to owning requester.
REQ-012 resp_ready  in  NUM_REQ  per-requester result accept.
REQ-013 resp_data  out  DATA_WIDTH  shared result bus, qualified by resp_valid.
REQ-014 mc_data_in_valid  out  NUM_FN_CALLS  lane valid mask to memory_compute.
REQ-015 mc_data_in_ready  in  1  memory_compute batch accept.
REQ-016 mc_data_in  out  NUM_FN_CALLS*FN_CALL_WIDTH  lane i in bits [(i+1)*FN_CALL_WIDTH-1 : i*FN_CALL_WIDTH].
REQ-017 mc_data_out_valid  in  1  memory_compute result valid.
REQ-018 mc_data_out_ready  out  1  result accept to memory_compute.
REQ-019 mc_data_out  in  NUM_FN_CALLS*DATA_WIDTH  lane results, same lane packing as mc_data_in.
REQ-020 busy  out  1  high in any state other than COLLECT with zero lanes filled.

Function
REQ-021 FSM states COLLECT, ISSUE, WAIT, RETURN; one batch outstanding at most.
REQ-022 COLLECT: round-robin grant among asserted req_valid, starting at pointer; req_ready one-hot to winner; none when batch full.
REQ-023 Grant transfer (req_valid&req_ready) writes req_data into next free lane (lane 0 first) and records owner ID (clog2(NUM_REQ) bits); pointer becomes winner+1 mod NUM_REQ.
REQ-024 Same requester may fill several lanes of one batch on consecutive cycles.
REQ-025 Timeout counter clears at batch start, counts each cycle once >=1 lane filled; COLLECT->ISSUE when lanes==NUM_FN_CALLS or counter==TIMEOUT-1.
REQ-026 Lane fill and timeout expiry in same cycle: the fill is kept, then ISSUE.
REQ-027 ISSUE: mc_data_in_valid = filled-lane mask, unfilled lanes data zero; held stable until mc_data_in_ready; ISSUE->WAIT on handshake.
REQ-028 WAIT: mc_data_out_ready=1; on mc_data_out_valid capture all lane results, WAIT->RETURN; mc_data_out_ready=0 in all other states.
REQ-029 RETURN: lanes returned in order 0..filled-1, one per handshake; resp_valid one-hot at owner, resp_data = lane result; stall while owner's resp_ready low.
REQ-030 Last lane handshake: RETURN->COLLECT, lane count and counter zero; req_ready low during ISSUE/WAIT/RETURN.
REQ-031 Arithmetic: lane count 0..NUM_FN_CALLS, counter clog2(TIMEOUT)+1 bits, no wrap possible.

Reset
REQ-032 rst asserted: state COLLECT, lanes 0, counter 0, pointer 0; req_ready, resp_valid, mc_data_in_valid, mc_data_out_ready all 0; resp_data and mc_data_in 0.
REQ-033 Reset mid-operation abandons the batch with no response; memory_compute shall be drained or reset alongside at system level.

Structure
REQ-034 Shared package memory_compute_pkg holds FSM state enum and parameter defaults.
REQ-035 Sub-module rr_arbiter (NUM_REQ requests, pointer in, one-hot grant out).

Verification
REQ-036 Four requesters each send one call 8'h12,8'h23,8'h34,8'h45 same cycle -> lanes 0..3 = req0..3, full-batch issue, results 8'h02,8'h06,8'h0C,8'h14 to req0..3 in order.
REQ-037 Only req2 sends 8'h56, TIMEOUT=16 -> issue 16 cycles after grant, mask 4'b0001, other lanes 0, result 8'h1E to req2 only.
REQ-038 req1 holds valid continuously with 8'h78 -> occupies all 4 lanes, four responses 8'h38 to req1.
REQ-039 mc_data_in_ready low 5 cycles in ISSUE -> mask/data stable throughout; resp_ready of owner low 3 cycles -> resp_valid/resp_data held.
REQ-040 rst pulsed during WAIT -> all outputs zero next edge, no resp_valid, pointer 0, next grant to req0.
